// File: rtl/spi_cmd_pkg.sv
// Shared command codes, FSM state encoding and status-byte layout for the SPI command sequencer.
package spi_cmd_pkg;

    localparam logic [7:0] CMD_WRITE  = 8'h01;
    localparam logic [7:0] CMD_READ   = 8'h02;
    localparam logic [7:0] CMD_STATUS = 8'h03;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_WDATA,
        ST_RDATA,
        ST_DISCARD
    } state_t;

    typedef struct packed {
        logic       last_ok;
        logic       underrun;
        logic [1:0] rsvd;
        logic [3:0] err_lo;
    } status_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/spi_cmd_regbank.sv
// Config register bank: NUM_REGS bytes, one synchronous write port, combinational read mux.
module spi_cmd_regbank #(
    parameter int         NUM_REGS  = 4,
    parameter int         ADDR_W    = $clog2(NUM_REGS),
    parameter logic [7:0] THR_RESET = 8'd30
) (
    input  logic                  clk_in,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [ADDR_W-1:0]     i_waddr,
    input  logic [7:0]            i_wdata,
    input  logic [ADDR_W-1:0]     i_raddr,
    output logic [7:0]            o_rdata,
    output logic [NUM_REGS*8-1:0] o_regs
);

    logic [7:0] r_regs [NUM_REGS];

    // Reg0 is the LED threshold and comes out of reset at THR_RESET.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= (i == 0) ? THR_RESET : 8'h00;
            end
        end else if (i_we) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_regs[i_raddr];

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign o_regs[8*g +: 8] = r_regs[g];
    end

endmodule

// File: rtl/spi_cmd_sequencer.sv
// Frame-level SPI command sequencer: decodes CMD/ADDR/DATA bytes, drives MISO replies, tracks frame errors.
module spi_cmd_sequencer
    import spi_cmd_pkg::*;
#(
    parameter int         NUM_REGS  = 4,
    parameter int         ADDR_W    = $clog2(NUM_REGS),
    parameter logic [7:0] THR_RESET = 8'd30
) (
    input  logic                  clk_in,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic                  frame_end,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_byte,
    output logic                  tx_valid,
    output logic [7:0]            tx_byte,
    input  logic                  tx_ready,
    output logic [7:0]            cfg_threshold,
    output logic [NUM_REGS*8-1:0] cfg_regs,
    output logic                  frame_ok,
    output logic                  frame_err,
    output logic [7:0]            err_count
);

    localparam logic [7:0] NUM_REGS_B = 8'(NUM_REGS);

    state_t            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_is_write, r_is_status, r_has_data;
    logic              r_tx_valid, r_frame_ok, r_frame_err;
    logic [7:0]        r_tx_byte, r_err_count;
    logic              r_underrun, r_last_ok;

    state_t            w_state_byte;
    logic              w_has_data_byte, w_frame_good, w_addr_ok, w_we;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [7:0]        w_rd_data;
    status_t           w_status;

    assign w_addr_ok = (rx_byte < NUM_REGS_B);
    assign w_we      = (r_state == ST_WDATA) && rx_valid && !frame_start;
    assign w_rd_addr = (r_state == ST_ADDR) ? rx_byte[ADDR_W-1:0] : r_ptr + ADDR_W'(1);
    assign w_status  = status_t'({r_last_ok, r_underrun, 2'b00, r_err_count[3:0]});

    // State as it stands once this cycle's byte is consumed; frame_end is judged against it.
    always_comb begin
        w_state_byte    = r_state;
        w_has_data_byte = r_has_data;
        if (rx_valid) begin
            case (r_state)
                ST_CMD: begin
                    if (rx_byte == CMD_WRITE || rx_byte == CMD_READ) w_state_byte = ST_ADDR;
                    else if (rx_byte == CMD_STATUS)                  w_state_byte = ST_RDATA;
                    else                                             w_state_byte = ST_DISCARD;
                end
                ST_ADDR: begin
                    w_has_data_byte = 1'b0;
                    if (!w_addr_ok)      w_state_byte = ST_DISCARD;
                    else if (r_is_write) w_state_byte = ST_WDATA;
                    else                 w_state_byte = ST_RDATA;
                end
                ST_WDATA: w_has_data_byte = 1'b1;
                default: ;
            endcase
        end
        w_frame_good = ((w_state_byte == ST_WDATA) && w_has_data_byte) ||
                       (w_state_byte == ST_RDATA);
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_is_write  <= 1'b0;
            r_is_status <= 1'b0;
            r_has_data  <= 1'b0;
            r_tx_valid  <= 1'b0;
            r_tx_byte   <= 8'h00;
            r_frame_ok  <= 1'b0;
            r_frame_err <= 1'b0;
            r_err_count <= 8'h00;
            r_underrun  <= 1'b0;
            r_last_ok   <= 1'b0;
        end else begin
            r_frame_ok  <= 1'b0;
            r_frame_err <= 1'b0;
            if (r_tx_valid && tx_ready) r_tx_valid <= 1'b0;

            if (frame_start) begin
                if (r_state != ST_IDLE) begin
                    r_frame_err <= 1'b1;
                    r_last_ok   <= 1'b0;
                    r_err_count <= sat_inc8(r_err_count);
                end
                r_state    <= ST_CMD;
                r_tx_valid <= 1'b0;
                r_has_data <= 1'b0;
            end else if (r_state != ST_IDLE) begin
                if (rx_valid) begin
                    case (r_state)
                        ST_CMD: begin
                            r_is_write  <= (rx_byte == CMD_WRITE);
                            r_is_status <= (rx_byte == CMD_STATUS);
                            if (rx_byte == CMD_STATUS) begin
                                r_tx_byte  <= w_status;
                                r_tx_valid <= 1'b1;
                            end
                        end
                        ST_ADDR: begin
                            if (w_addr_ok) begin
                                r_ptr <= rx_byte[ADDR_W-1:0];
                                if (!r_is_write) begin
                                    r_tx_byte  <= w_rd_data;
                                    r_tx_valid <= 1'b1;
                                end
                            end
                        end
                        ST_WDATA: r_ptr <= r_ptr + ADDR_W'(1);
                        ST_RDATA: begin
                            if (r_tx_valid && !tx_ready) r_underrun <= 1'b1;
                            r_ptr      <= r_ptr + ADDR_W'(1);
                            r_tx_byte  <= r_is_status ? w_status : w_rd_data;
                            r_tx_valid <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                r_state    <= w_state_byte;
                r_has_data <= w_has_data_byte;

                if (frame_end) begin
                    r_state    <= ST_IDLE;
                    r_tx_valid <= 1'b0;
                    if (w_frame_good) begin
                        r_frame_ok <= 1'b1;
                        r_last_ok  <= 1'b1;
                    end else begin
                        r_frame_err <= 1'b1;
                        r_last_ok   <= 1'b0;
                        r_err_count <= sat_inc8(r_err_count);
                    end
                end
            end
        end
    end

    spi_cmd_regbank #(
        .NUM_REGS  (NUM_REGS),
        .ADDR_W    (ADDR_W),
        .THR_RESET (THR_RESET)
    ) u_regbank (
        .clk_in  (clk_in),
        .rst     (rst),
        .i_we    (w_we),
        .i_waddr (r_ptr),
        .i_wdata (rx_byte),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd_data),
        .o_regs  (cfg_regs)
    );

    assign tx_valid      = r_tx_valid;
    assign tx_byte       = r_tx_byte;
    assign frame_ok      = r_frame_ok;
    assign frame_err     = r_frame_err;
    assign err_count     = r_err_count;
    assign cfg_threshold = cfg_regs[7:0];

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Scoreboard bench for spi_cmd_sequencer: directed frames, queued expected MISO bytes and frame outcomes.
module tb_spi_cmd_sequencer;

    logic        clk_in = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0;
    logic        frame_end = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        tx_ready = 1'b1;
    logic        tx_valid;
    logic [7:0]  tx_byte;
    logic [7:0]  cfg_threshold;
    logic [31:0] cfg_regs;
    logic        frame_ok;
    logic        frame_err;
    logic [7:0]  err_count;

    int n_vec = 0;
    int n_bad = 0;
    logic [7:0] exp_tx[$];
    logic       exp_ev[$];
    logic [7:0] mon_tx;
    logic       mon_ev;

    spi_cmd_sequencer #(.NUM_REGS(4), .THR_RESET(8'd30)) dut (
        .clk_in        (clk_in),
        .rst           (rst),
        .frame_start   (frame_start),
        .frame_end     (frame_end),
        .rx_valid      (rx_valid),
        .rx_byte       (rx_byte),
        .tx_valid      (tx_valid),
        .tx_byte       (tx_byte),
        .tx_ready      (tx_ready),
        .cfg_threshold (cfg_threshold),
        .cfg_regs      (cfg_regs),
        .frame_ok      (frame_ok),
        .frame_err     (frame_err),
        .err_count     (err_count)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // Monitor: every accepted MISO byte and every frame outcome pulse is matched against the queues.
    always @(negedge clk_in) begin
        if (tx_valid && tx_ready) begin
            n_vec++;
            if (exp_tx.size() == 0) begin
                n_bad++;
                $display("FAIL tx_byte: got %h, expected no transfer", tx_byte);
            end else begin
                mon_tx = exp_tx.pop_front();
                if (tx_byte !== mon_tx) begin
                    n_bad++;
                    $display("FAIL tx_byte: got %h, expected %h", tx_byte, mon_tx);
                end
            end
        end
        if (frame_ok || frame_err) begin
            n_vec++;
            if (frame_ok && frame_err) begin
                n_bad++;
                $display("FAIL frame_pulse: frame_ok and frame_err both high");
            end else if (exp_ev.size() == 0) begin
                n_bad++;
                $display("FAIL frame_pulse: got ok=%0b err=%0b, expected none", frame_ok, frame_err);
            end else begin
                mon_ev = exp_ev.pop_front();
                if (frame_ok !== mon_ev) begin
                    n_bad++;
                    $display("FAIL frame_pulse: got ok=%0b err=%0b, expected ok=%0b", frame_ok, frame_err, mon_ev);
                end
            end
        end
    end

    task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic fstart();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
    endtask

    task automatic fend();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        tick();
        tick();
    endtask

    task automatic rxb(input logic [7:0] b, input logic with_end);
        rx_valid  = 1'b1;
        rx_byte   = b;
        frame_end = with_end;
        tick();
        rx_valid  = 1'b0;
        frame_end = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        do_reset();
        check8("rst_threshold", cfg_threshold, 8'd30);
        check8("rst_err_count", err_count, 8'h00);
        check8("rst_tx_valid", {7'b0, tx_valid}, 8'h00);
        check8("rst_tx_byte", tx_byte, 8'h00);

        exp_ev.push_back(1'b1);
        fstart(); rxb(8'h01, 0); rxb(8'h00, 0); rxb(8'h2A, 0); fend();
        check8("wr_reg0", cfg_regs[7:0], 8'h2A);
        check8("wr_err_count", err_count, 8'h00);

        exp_ev.push_back(1'b1);
        fstart(); rxb(8'h01, 0); rxb(8'h03, 0); rxb(8'h11, 0); rxb(8'h22, 0); fend();
        check8("wrap_reg3", cfg_regs[31:24], 8'h11);
        check8("wrap_reg0", cfg_regs[7:0], 8'h22);
        check8("wrap_threshold", cfg_threshold, 8'h22);

        exp_ev.push_back(1'b1);
        fstart(); rxb(8'h01, 0); rxb(8'h01, 0); rxb(8'hA5, 0); rxb(8'h5A, 0); fend();
        check8("wr_reg1", cfg_regs[15:8], 8'hA5);
        check8("wr_reg2", cfg_regs[23:16], 8'h5A);

        exp_tx.push_back(8'hA5);
        exp_tx.push_back(8'h5A);
        exp_ev.push_back(1'b1);
        fstart(); rxb(8'h02, 0); rxb(8'h01, 0); rxb(8'hFF, 0); rxb(8'hFF, 1); tick();

        exp_tx.push_back(8'h80);
        exp_ev.push_back(1'b1);
        fstart(); rxb(8'h03, 0); rxb(8'h00, 1); tick();

        tx_ready = 1'b0;
        exp_ev.push_back(1'b1);
        fstart(); rxb(8'h02, 0); rxb(8'h01, 0);
        check8("hold_tx_valid", {7'b0, tx_valid}, 8'h01);
        check8("hold_tx_byte", tx_byte, 8'hA5);
        rxb(8'hFF, 1);
        check8("end_tx_valid", {7'b0, tx_valid}, 8'h00);
        tx_ready = 1'b1;
        exp_tx.push_back(8'hC0);
        exp_ev.push_back(1'b1);
        fstart(); rxb(8'h03, 0); rxb(8'h00, 1); tick();

        do_reset();
        exp_ev.push_back(1'b0);
        fstart(); rxb(8'h7F, 0); fend();
        exp_ev.push_back(1'b0);
        fstart(); rxb(8'h01, 0); fend();
        exp_ev.push_back(1'b0);
        fstart(); rxb(8'h02, 0); rxb(8'h09, 0); fend();
        check8("err_count_3", err_count, 8'h03);
        exp_tx.push_back(8'h03);
        exp_ev.push_back(1'b1);
        fstart(); rxb(8'h03, 0); rxb(8'h00, 1); tick();
        frame_end = 1'b1; tick(); frame_end = 1'b0; tick();
        check8("idle_end_err_count", err_count, 8'h03);

        do_reset();
        exp_ev.push_back(1'b0);
        fstart(); rxb(8'h01, 0); rxb(8'h00, 0); rxb(8'hAA, 0);
        fstart();
        exp_ev.push_back(1'b1);
        rxb(8'h01, 0); rxb(8'h00, 0); rxb(8'h05, 1); tick();
        check8("abort_reg0", cfg_regs[7:0], 8'h05);
        check8("abort_err_count", err_count, 8'h01);

        fstart(); rxb(8'h01, 0); rxb(8'h02, 0); rxb(8'h77, 0);
        check8("pre_rst_reg2", cfg_regs[23:16], 8'h77);
        do_reset();
        check8("mid_rst_reg2", cfg_regs[23:16], 8'h00);
        check8("mid_rst_threshold", cfg_threshold, 8'd30);
        check8("mid_rst_err_count", err_count, 8'h00);

        repeat (4) tick();
        check8("tx_queue_left", 8'(exp_tx.size()), 8'h00);
        check8("event_queue_left", 8'(exp_ev.size()), 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
